// File: rtl/exec_ctrl.sv
// exec_ctrl: sequences one 16-bit instruction at a time through
// register-file read, ALU execute and register-file write-back.
//
//  state | meaning
//  IDLE  | ready for an instruction; NOP/illegal retire here in one cycle
//  READ  | register-file read of AA/BA in flight
//  EXEC  | operands valid; result and flags registered
//  WB    | single-cycle write of result to DA, done pulses
module exec_ctrl #(
  parameter bit LDI_SEXT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] rf_a,
  input  logic [15:0] rf_b,
  output logic [15:0] rf_d,
  output logic [3:0]  rf_da,
  output logic [3:0]  rf_aa,
  output logic [3:0]  rf_ba,
  output logic [1:0]  rf_rw,
  output logic        rf_en,
  output logic        done,
  output logic        illegal,
  output logic        zf,
  output logic        cf
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

  state_t      state;
  logic [3:0]  op_q;
  logic [3:0]  da_q;
  logic [15:0] alu_res;
  logic        alu_c;
  logic [16:0] wide;
  logic [15:0] ldi_val;

  assign ldi_val = LDI_SEXT ? {{8{instr[7]}}, instr[7:0]} : {8'h00, instr[7:0]};

  // ALU on the latched opcode; operands come straight from the register file in EXEC
  always_comb begin
    alu_res = rf_a;
    alu_c   = 1'b0;
    wide    = 17'd0;
    case (op_q)
      4'h1: alu_res = rf_a;
      4'h2: begin
        wide    = {1'b0, rf_a} + {1'b0, rf_b};
        alu_res = wide[15:0];
        alu_c   = wide[16];
      end
      4'h3: begin
        wide    = {1'b0, rf_a} - {1'b0, rf_b};
        alu_res = wide[15:0];
        alu_c   = wide[16];
      end
      4'h4: alu_res = rf_a & rf_b;
      4'h5: alu_res = rf_a | rf_b;
      4'h6: alu_res = rf_a ^ rf_b;
      4'h7: alu_res = ~rf_a;
      4'h8: begin
        alu_res = {rf_a[14:0], 1'b0};
        alu_c   = rf_a[15];
      end
      4'h9: begin
        alu_res = {1'b0, rf_a[15:1]};
        alu_c   = rf_a[0];
      end
      default: begin
        alu_res = rf_a;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Control FSM with every output registered; done/illegal default low so they pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 4'h0;
      da_q        <= 4'h0;
      instr_ready <= 1'b1;
      rf_d        <= 16'h0000;
      rf_da       <= 4'h0;
      rf_aa       <= 4'h0;
      rf_ba       <= 4'h0;
      rf_rw       <= RW_IDLE;
      rf_en       <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      zf          <= 1'b0;
      cf          <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          rf_en <= 1'b0;
          rf_rw <= RW_IDLE;
          if (instr_valid) begin
            op_q <= instr[15:12];
            da_q <= instr[11:8];
            if (instr[15:12] == 4'h0) begin
              done <= 1'b1;
            end else if (instr[15:12] <= 4'h9) begin
              state       <= READ;
              instr_ready <= 1'b0;
              rf_aa       <= instr[7:4];
              rf_ba       <= instr[3:0];
              rf_rw       <= RW_READ;
              rf_en       <= 1'b1;
            end else if (instr[15:12] == 4'hA) begin
              state       <= WB;
              instr_ready <= 1'b0;
              rf_d        <= ldi_val;
              zf          <= (ldi_val == 16'h0000);
              cf          <= 1'b0;
              rf_da       <= instr[11:8];
              rf_rw       <= RW_WRITE;
              rf_en       <= 1'b1;
              done        <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        READ: begin
          state <= EXEC;
          rf_en <= 1'b0;
          rf_rw <= RW_IDLE;
        end
        EXEC: begin
          state <= WB;
          rf_d  <= alu_res;
          zf    <= (alu_res == 16'h0000);
          cf    <= alu_c;
          rf_da <= da_q;
          rf_rw <= RW_WRITE;
          rf_en <= 1'b1;
          done  <= 1'b1;
        end
        WB: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          rf_rw       <= RW_IDLE;
          rf_en       <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          rf_rw       <= RW_IDLE;
          rf_en       <= 1'b0;
        end
      endcase
    end
  end

endmodule
